// File: rtl/iir_channel_scheduler_if.sv
// Channel request/data, initial-condition load and result bundle for the
// shared IIR channel scheduler.
interface iir_channel_scheduler_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 6
);
  localparam int unsigned CW = $clog2(NCH);

  logic [NCH-1:0]   req;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   grant;
  logic             ic_load;
  logic [CW-1:0]    ic_chan;
  logic [W-1:0]     ic_data;
  logic             out_valid;
  logic [CW-1:0]    out_chan;
  logic [W-1:0]     out_data;

  modport master (
    output req, in_data, ic_load, ic_chan, ic_data,
    input  grant, out_valid, out_chan, out_data
  );

  modport slave (
    input  req, in_data, ic_load, ic_chan, ic_data,
    output grant, out_valid, out_chan, out_data
  );
endinterface

// File: rtl/iir_channel_scheduler.sv
// One first-order IIR datapath (y = x + y_prev/2) time-shared round-robin
// across NCH channels, with a per-channel feedback state bank.
module iir_channel_scheduler #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 6
) (
  input  logic                    clock,
  input  logic                    rst,
  iir_channel_scheduler_if.slave  bus
);
  localparam int unsigned CW = $clog2(NCH);

  typedef enum logic {IDLE, CALC} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]   x_q, x_d;
  logic [CW-1:0]  ch_q, ch_d;
  logic [NCH-1:0] grant_q, grant_d;
  logic           out_valid_q, out_valid_d;
  logic [CW-1:0]  out_chan_q, out_chan_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [W-1:0]   st_q [NCH];
  logic [W-1:0]   st_d [NCH];

  logic [W-1:0]   in_arr [NCH];
  logic           sel_found;
  logic [CW-1:0]  sel_idx;
  logic [CW-1:0]  idx;
  logic [W-1:0]   y;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      in_arr[i] = bus.in_data[i*W +: W];
    end
  end

  // Round-robin search starting at ptr; CW-bit wrap gives mod NCH for free.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = ptr_q + CW'(k);
      if (!sel_found && bus.req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    x_d         = x_q;
    ch_d        = ch_q;
    grant_d     = '0;
    out_valid_d = 1'b0;
    out_chan_d  = out_chan_q;
    out_data_d  = out_data_q;
    st_d        = st_q;
    // W-bit add wraps exactly like a W+1-bit sum truncated to W bits.
    y           = x_q + (st_q[ch_q] >> 1);

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          x_d              = in_arr[sel_idx];
          ch_d             = sel_idx;
          grant_d[sel_idx] = 1'b1;
          ptr_d            = sel_idx + CW'(1);
          state_d          = CALC;
        end
      end
      CALC: begin
        st_d[ch_q]  = y;
        out_data_d  = y;
        out_chan_d  = ch_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Applied last so an initial-condition load overrides a same-cycle result write.
    if (bus.ic_load) begin
      st_d[bus.ic_chan] = bus.ic_data;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      x_q         <= '0;
      ch_q        <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        st_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      x_q         <= x_d;
      ch_q        <= ch_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_data_q  <= out_data_d;
      st_q        <= st_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: doc/iir_channel_scheduler.md
# iir_channel_scheduler

Time-multiplexed controller that shares one first-order IIR datapath (y = x + y_prev/2, W-bit) among NCH independent sample streams. It arbitrates per-channel sample requests round-robin, holds each channel's feedback state in a register bank, and supports per-channel initial-condition loading. It sits between the per-channel sample sources and the downstream sample sink, replacing one IIR instance per channel.

## Interface
- NCH, 4, number of channels; power of two, ≥2
- W, 6, sample/state width, unsigned
- CW, $clog2(NCH), channel index width (derived)

- clock  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  NCH  per-channel sample request; held with its data until granted
- in_data  input  NCH*W  channel i sample at bits [i*W +: W]
- grant  output  NCH  one-hot, one-cycle pulse: channel's sample was accepted
- ic_load  input  1  load initial condition this cycle
- ic_chan  input  CW  target channel for ic_load
- ic_data  input  W  initial-condition value
- out_valid  output  1  one-cycle pulse, out_data/out_chan valid
- out_chan  output  CW  channel of emitted result
- out_data  output  W  filtered result

## Operation
- State bank st[0..NCH-1], W bits each; the feedback term for channel c is st[c].
- FSM states IDLE, CALC.
- IDLE: if req is zero, stay. Otherwise pick the first set req[i] searching ptr, ptr+1, … mod NCH. On the edge:
  - latch x = in_data[i], ch = i
  - grant[i] <= 1
  - ptr <= (i+1) mod NCH
  - go to CALC
- CALC:
  - y = (x + (st[ch] >> 1)) mod 2^W, computed at W+1 bits and truncated (wrap, no saturation)
  - On the edge: st[ch] <= y, out_data <= y, out_chan <= ch, out_valid <= 1, grant <= 0; go to IDLE.
- ic_load:
  - Accepted in any FSM state.
  - Writes st[ic_chan] <= ic_data on the edge.
  - If it coincides with the CALC write to the same channel, ic_data wins the stored value; the emitted y still uses the pre-load state.
  - A load during the accepting IDLE cycle is visible to the following CALC.
- Channels not selected keep their state untouched.
- Requester rule:
  - Keep req[i] and data stable until grant[i] is observed high.
  - Update or drop req on the edge ending the grant cycle.
  - The arbiter never samples req during CALC.

## Timing
- Reset (async, immediate):
  - grant = 0, out_valid = 0, out_chan = 0, out_data = 0
  - all st = 0, ptr = 0, FSM = IDLE
- Reset mid-CALC abandons the sample; no out_valid is produced and the state write is discarded.
- Latency:
  - acceptance edge E (IDLE→CALC)
  - grant high during cycle E..E+1
  - out_valid high during cycle E+1..E+2
- Throughput: one sample per 2 cycles; at most one grant per 2 cycles.
- out_valid and grant are never high in the same cycle.
- out_data, out_chan hold their last value when out_valid is low.
- Simultaneous requests are served in round-robin order. With all req held high, the grant sequence is ptr, ptr+1, … with no channel starved; each channel waits at most 2·NCH cycles.

## Test plan
- Single channel 0, st = 0, inputs 2, 4, 6, 3 back-to-back → out_data 2, 5, 8, 7, out_chan 0; each out_valid exactly 1 cycle after its grant.
- ic_load ch1 = 10, then ch1 sample 2 → out 7. Then ch0 sample 4 → out 4 (ch0 state unaffected).
- Wrap: ic_load ch2 = 62, sample 63 → out 30 (94 mod 64); the next sample 0 → out 15.
- All four req held from reset → grants 0, 1, 2, 3, 0, … one every 2 cycles. Drop req[1] → sequence 0, 2, 3, 0.
- ic_load ch3 = 20 in the same cycle as a ch3 CALC with st = 8, x = 1 → out 5 emitted, st[3] reads back 20 (next x = 0 → out 10).
- Assert rst during CALC → no out_valid, all outputs 0 immediately. After release, ch0 sample 6 → out 6 (state cleared), ptr restarts at 0.
